// File: rtl/pwm_bank_pkg.sv
// Shared register map constants for the multi-channel PWM bank.
package pwm_bank_pkg;

    localparam logic [7:0] ID_ADDR      = 8'h00;
    localparam logic [7:0] EN_ADDR      = 8'h01;
    localparam logic [7:0] POL_ADDR     = 8'h02;
    localparam logic [7:0] LOAD_ADDR    = 8'h03;
    localparam logic [7:0] INT_STS_ADDR = 8'h04;
    localparam logic [7:0] INT_EN_ADDR  = 8'h05;
    localparam logic [7:0] SYNC_ADDR    = 8'h06;

    localparam logic [7:0] CHN_BASE   = 8'h10;
    localparam logic [7:0] CHN_STRIDE = 8'h10;

    localparam logic [3:0] FTW_OFS   = 4'd0;
    localparam logic [3:0] DUTY_OFS  = 4'd4;
    localparam logic [3:0] PHASE_OFS = 4'd8;

    localparam logic [7:0] ID_VAL = 8'hB7;

endpackage

// File: rtl/pwm_chn.sv
// One PWM channel: shadow/active FTW and duty, pending load, phase accumulator, output register.
// PWM_PHASE_EN adds a per-channel PHASE register used as the accumulator start value.
module pwm_chn
    import pwm_bank_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pol,
    input  logic       sync,
    input  logic       load_set,
    input  logic       wr,
    input  logic [3:0] ofs,
    input  logic [7:0] din,
    output logic [7:0] rd_byte,
    output logic       pending,
    output logic       load_done,
    output logic       pwm
);
    localparam int NB = ACC_W / 8;

    logic [ACC_W-1:0] ftw_sh, duty_sh, ftw_act, duty_act, acc, start;
    logic [ACC_W:0]   sum;
    logic             apply;

    // Carry out of the accumulator marks the period boundary; a disabled channel loads at once.
    assign sum       = {1'b0, acc} + {1'b0, ftw_act};
    assign apply     = pending & (~en | sum[ACC_W]);
    assign load_done = apply;

`ifdef PWM_PHASE_EN
    logic [ACC_W-1:0] phase;
    assign start = phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (wr) begin
            for (int i = 0; i < NB; i++)
                if (ofs == PHASE_OFS + 4'(i)) phase[8*i +: 8] <= din;
        end
    end
`else
    assign start = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_sh   <= '0;
            duty_sh  <= '0;
            ftw_act  <= '0;
            duty_act <= '0;
            acc      <= '0;
            pending  <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            if (wr) begin
                for (int i = 0; i < NB; i++) begin
                    if (ofs == FTW_OFS + 4'(i))  ftw_sh[8*i +: 8]  <= din;
                    if (ofs == DUTY_OFS + 4'(i)) duty_sh[8*i +: 8] <= din;
                end
            end
            // Active registers take the pre-edge shadow, so a coincident shadow write waits.
            if (apply) begin
                ftw_act  <= ftw_sh;
                duty_act <= duty_sh;
            end
            pending <= load_set | (pending & ~apply);
            acc     <= (~en | sync) ? start : sum[ACC_W-1:0];
            pwm     <= en ? ((acc < duty_act) ^ pol) : pol;
        end
    end

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (ofs == FTW_OFS + 4'(i))  rd_byte = ftw_sh[8*i +: 8];
            if (ofs == DUTY_OFS + 4'(i)) rd_byte = duty_sh[8*i +: 8];
`ifdef PWM_PHASE_EN
            if (ofs == PHASE_OFS + 4'(i)) rd_byte = phase[8*i +: 8];
`endif
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel DDS-style PWM bank on the 8-bit local bus; bus decode, global registers, interrupt.
// Optional PWM_PHASE_EN gives each channel a phase start value for aligned outputs.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int CHN_NUMS = 4,
    parameter int ACC_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          lbs_addr,
    input  logic [7:0]          lbs_din,
    output logic [7:0]          lbs_dout,
    input  logic                lbs_we,
    input  logic                lbs_re,
    input  logic                lbs_cs_n,
    output logic [CHN_NUMS-1:0] pwm_o,
    output logic                pwm_int
);
    localparam int N = CHN_NUMS;

    logic              wr, rd, sync;
    logic [N-1:0]      en, pol, int_en, int_sts;
    logic [N-1:0]      load_set, w1c, pending, load_done, chn_wr;
    logic [N-1:0][7:0] chn_rd;
    logic [7:0]        rdata;

    assign wr       = lbs_we & ~lbs_cs_n;
    assign rd       = lbs_re & ~lbs_cs_n;
    assign sync     = wr && (lbs_addr == SYNC_ADDR);
    assign load_set = (wr && lbs_addr == LOAD_ADDR) ? lbs_din[N-1:0] : '0;
    assign w1c      = (wr && lbs_addr == INT_STS_ADDR) ? lbs_din[N-1:0] : '0;

    for (genvar c = 0; c < N; c++) begin : g_chn
        assign chn_wr[c] = wr && ((lbs_addr & 8'hF0) == CHN_BASE + CHN_STRIDE * 8'(c));

        pwm_chn #(.ACC_W(ACC_W)) u_chn (
            .clk      (clk),
            .rst      (rst),
            .en       (en[c]),
            .pol      (pol[c]),
            .sync     (sync),
            .load_set (load_set[c]),
            .wr       (chn_wr[c]),
            .ofs      (lbs_addr[3:0]),
            .din      (lbs_din),
            .rd_byte  (chn_rd[c]),
            .pending  (pending[c]),
            .load_done(load_done[c]),
            .pwm      (pwm_o[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= '0;
            pol      <= '0;
            int_en   <= '0;
            int_sts  <= '0;
            pwm_int  <= 1'b0;
            lbs_dout <= '0;
        end else begin
            if (wr) begin
                case (lbs_addr)
                    EN_ADDR:     en     <= lbs_din[N-1:0];
                    POL_ADDR:    pol    <= lbs_din[N-1:0];
                    INT_EN_ADDR: int_en <= lbs_din[N-1:0];
                    default: ;
                endcase
            end
            // Hardware set beats a same-cycle clear.
            int_sts <= (int_sts & ~w1c) | load_done;
            pwm_int <= |(int_sts & int_en);
            if (rd) lbs_dout <= rdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (lbs_addr)
            ID_ADDR:      rdata = ID_VAL;
            EN_ADDR:      rdata[N-1:0] = en;
            POL_ADDR:     rdata[N-1:0] = pol;
            LOAD_ADDR:    rdata[N-1:0] = pending;
            INT_STS_ADDR: rdata[N-1:0] = int_sts;
            INT_EN_ADDR:  rdata[N-1:0] = int_en;
            default: begin
                for (int c = 0; c < N; c++)
                    if ((lbs_addr & 8'hF0) == CHN_BASE + CHN_STRIDE * 8'(c)) rdata = chn_rd[c];
            end
        endcase
    end

endmodule
